// File: rtl/program_loader.sv
// program_loader: UART boot loader that parses framed load records into CPU memory.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   rx        - UART receive line (8N1, idle high, asynchronous)
//   mem_we    - one-cycle memory write strobe
//   mem_addr  - memory write address
//   mem_wdata - memory write data {8'h00, payload byte}
//   cpu_hold  - holds the CPU in reset until a good record loads
//   load_done - one-cycle pulse when a record passes its checksum
//   load_err  - sticky error flag, cleared by the next accepted sync byte
module program_loader #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_SYNC, GET_BASE, GET_LEN, GET_DATA, GET_SUM} fr_state_t;

    logic             r_rx_s1, r_rx_s2, r_rx_prev;
    rx_state_t        r_rx_state, w_rx_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             w_half, w_tick, w_rx_valid, w_rx_ferr, w_abort;

    fr_state_t        r_fr_state, w_fr_next;
    logic [7:0]       r_base, r_idx, r_sum;
    logic [8:0]       r_remain;

    assign w_half  = r_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1);
    assign w_tick  = r_cnt == CNT_W'(CLKS_PER_BIT - 1);
    // A framing error only matters once a record has started.
    assign w_abort = w_rx_ferr && r_fr_state != WAIT_SYNC;

    always_comb begin
        w_rx_next  = r_rx_state;
        w_rx_valid = 1'b0;
        w_rx_ferr  = 1'b0;
        case (r_rx_state)
            RX_IDLE:  w_rx_next = (r_rx_prev && !r_rx_s2) ? RX_START : RX_IDLE;
            RX_START: w_rx_next = w_half ? (r_rx_s2 ? RX_IDLE : RX_DATA) : RX_START;
            RX_DATA:  w_rx_next = (w_tick && r_bit == 3'd7) ? RX_STOP : RX_DATA;
            RX_STOP: begin
                w_rx_next  = w_tick ? RX_IDLE : RX_STOP;
                w_rx_valid = w_tick && r_rx_s2;
                w_rx_ferr  = w_tick && !r_rx_s2;
            end
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
        end else begin
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_next;
            // Counter restarts on every state change and every bit sample.
            r_cnt      <= (r_rx_state == RX_IDLE || r_rx_state != w_rx_next || w_tick) ? '0 : r_cnt + 1'b1;
            if (r_rx_state == RX_DATA && w_tick) begin
                r_bit   <= r_bit + 1'b1;
                r_shift <= {r_rx_s2, r_shift[7:1]};
            end
        end
    end

    always_comb begin
        w_fr_next = r_fr_state;
        if (w_abort)
            w_fr_next = WAIT_SYNC;
        else if (w_rx_valid)
            case (r_fr_state)
                WAIT_SYNC: w_fr_next = (r_shift == SYNC_BYTE) ? GET_BASE : WAIT_SYNC;
                GET_BASE:  w_fr_next = GET_LEN;
                GET_LEN:   w_fr_next = GET_DATA;
                GET_DATA:  w_fr_next = (r_remain == 9'd1) ? GET_SUM : GET_DATA;
                default:   w_fr_next = WAIT_SYNC;
            endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fr_state <= WAIT_SYNC;
            r_base     <= '0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_remain   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            r_fr_state <= w_fr_next;
            mem_we     <= 1'b0;
            load_done  <= 1'b0;
            if (w_abort) begin
                load_err <= 1'b1;
                cpu_hold <= 1'b1;
            end else if (w_rx_valid) begin
                case (r_fr_state)
                    WAIT_SYNC: if (r_shift == SYNC_BYTE) begin
                        cpu_hold <= 1'b1;
                        load_err <= 1'b0;
                    end
                    GET_BASE: begin
                        r_base <= r_shift;
                        r_idx  <= '0;
                        r_sum  <= r_shift;
                    end
                    GET_LEN: begin
                        // LEN of zero encodes a full 256-byte record.
                        r_remain <= {r_shift == 8'h00, r_shift};
                        r_sum    <= r_sum + r_shift;
                    end
                    GET_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_base + r_idx;
                        mem_wdata <= {8'h00, r_shift};
                        r_sum     <= r_sum + r_shift;
                        r_idx     <= r_idx + 1'b1;
                        r_remain  <= r_remain - 1'b1;
                    end
                    GET_SUM: if (r_shift == r_sum) begin
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
                    end else begin
                        load_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed-vector bench for the UART program loader.
module tb_program_loader;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    logic [23:0] wq[$];

    typedef logic [7:0]  bytes_t [0:7];
    typedef logic [23:0] wr_t    [0:3];

    program_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
        if (load_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic send_n(input bytes_t b, input int n);
        for (int i = 0; i < n; i++) send_byte(b[i]);
        idle(4);
    endtask

    task automatic start_test;
        wq.delete();
        done_cnt = 0;
    endtask

    task automatic expect_writes(input string tag, input wr_t e, input int n);
        check({tag, "_nwr"}, wq.size(), n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_wr%0d", tag, i), i < wq.size() ? wq[i] : 24'hFFFFFF, e[i]);
    endtask

    task automatic expect_status(input string tag, input int done, input logic hold, input logic err);
        check({tag, "_done"}, done_cnt, done);
        check({tag, "_hold"}, cpu_hold, hold);
        check({tag, "_err"}, load_err, err);
    endtask

    initial begin
        idle(3);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 1);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        rst = 1'b1;
        idle(5);

        // 1: basic record
        start_test();
        send_n('{8'hA5, 8'h00, 8'h03, 8'hFF, 8'hFE, 8'h23, 0, 0}, 6);
        check("t1_hold_pre_sum", cpu_hold, 1);
        send_n('{8'h23, 0, 0, 0, 0, 0, 0, 0}, 1);
        expect_writes("t1", '{24'h0000FF, 24'h0100FE, 24'h020023, 0}, 3);
        expect_status("t1", 1, 0, 0);

        // 2: bad checksum
        start_test();
        send_n('{8'hA5, 8'h00, 8'h03, 8'hFF, 8'hFE, 8'h23, 8'h24, 0}, 7);
        expect_writes("t2", '{24'h0000FF, 24'h0100FE, 24'h020023, 0}, 3);
        expect_status("t2", 0, 1, 1);

        // 3: address wrap-around
        start_test();
        send_n('{8'hA5, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h67, 0}, 7);
        expect_writes("t3", '{24'hFE0011, 24'hFF0022, 24'h000033, 0}, 3);
        expect_status("t3", 1, 0, 0);

        // 4: junk bytes and a short glitch are ignored
        start_test();
        send_n('{8'h00, 8'h5A, 0, 0, 0, 0, 0, 0}, 2);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(3 * CPB);
        check("t4_junk_nwr", wq.size(), 0);
        expect_status("t4_junk", 0, 0, 0);
        send_n('{8'hA5, 8'h40, 8'h01, 8'h7E, 8'hBF, 0, 0, 0}, 5);
        expect_writes("t4", '{24'h40007E, 0, 0, 0}, 1);
        expect_status("t4", 1, 0, 0);

        // 5: framing error mid-record, then recovery
        start_test();
        send_n('{8'hA5, 8'h10, 8'h02, 8'hAB, 0, 0, 0, 0}, 4);
        send_byte(8'hCD, 1'b0);
        idle(CPB);
        expect_writes("t5", '{24'h1000AB, 0, 0, 0}, 1);
        expect_status("t5", 0, 1, 1);
        start_test();
        send_n('{8'hA5, 8'h20, 8'h01, 8'h55, 8'h76, 0, 0, 0}, 5);
        expect_writes("t5r", '{24'h200055, 0, 0, 0}, 1);
        expect_status("t5r", 1, 0, 0);

        // 6: reset during the second payload byte
        start_test();
        send_n('{8'hA5, 8'h30, 8'h03, 8'h11, 0, 0, 0, 0}, 4);
        check("t6_addr_pre", mem_addr, 8'h30);
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(3 * CPB);
        rst = 1'b0;
        #1;
        check("t6_rst_we", mem_we, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_wdata", mem_wdata, 0);
        check("t6_rst_hold", cpu_hold, 1);
        check("t6_rst_done", load_done, 0);
        check("t6_rst_err", load_err, 0);
        idle(4);
        rst = 1'b1;
        idle(12 * CPB);
        check("t6_abandon_nwr", wq.size(), 1);
        start_test();
        send_n('{8'hA5, 8'h30, 8'h02, 8'h12, 8'h34, 8'h78, 0, 0}, 6);
        expect_writes("t6", '{24'h300012, 24'h310034, 0, 0}, 2);
        expect_status("t6", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
